// File: rtl/prim_arbiter_pkg.sv
// prim_arbiter_pkg
// Shared types and helpers for the prim_arbiter_rr family.
//   arb_mode_e : arbitration mode selected per instance by the RoundRobin
//                parameter (ArbFixed = index 0 always highest priority,
//                ArbRoundRobin = rotating priority pointer).
//   arb_idx_w  : width of an index into n request ports, never below 1.
package prim_arbiter_pkg;

  typedef enum logic {
    ArbFixed      = 1'b0,
    ArbRoundRobin = 1'b1
  } arb_mode_e;

  function automatic int arb_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prim_arbiter_rr_pick.sv
// prim_arbiter_rr_pick
// Combinational rotate-priority finder: returns the first set request bit
// at or above ptr, wrapping past N-1 back to 0.
// Ports:
//   req   in  N     request vector
//   ptr   in  IdxW  starting index of the search (must be < N)
//   found out 1     at least one request is set
//   idx   out IdxW  winning index (0 when nothing is found)
module prim_arbiter_rr_pick #(
  parameter int N    = 8,
  parameter int IdxW = 3
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic            found,
  output logic [IdxW-1:0] idx
);

  logic [N-1:0]   mask;
  logic [2*N-1:0] req_dbl;

  // The low half keeps only requests at or above ptr; the high half holds
  // the full vector, so scanning upward through both halves gives the
  // wrapped search order without any modulo arithmetic.
  assign mask    = {N{1'b1}} << ptr;
  assign req_dbl = {req, req & mask};

  // Scan from the low end; the first hit wins. Hits in the high half are
  // folded back onto the real port index by subtracting N.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 2 * N; i++) begin
      if (!found && req_dbl[i]) begin
        found = 1'b1;
        idx   = (i < N) ? IdxW'(i) : IdxW'(i - N);
      end
    end
  end

endmodule

// File: rtl/prim_arbiter_rr.sv
// prim_arbiter_rr
// N:1 arbiter with fixed-priority or round-robin mode, a stable-grant lock
// that holds the selection while the sink stalls, and an optional
// multi-beat packet lock enabled by defining PRIM_ARBITER_PKT_LOCK_EN.
// Ports:
//   clk_i    in  1        clock
//   rst_i    in  1        asynchronous reset, active high
//   req_i    in  N        per-port request (valid)
//   data_i   in  DW x N   per-port data
//   last_i   in  N        per-port last-beat flag (packet lock builds only)
//   gnt_o    out N        one-hot0 grant, asserted on the handshake
//   idx_o    out IdxW     index of the selected port
//   valid_o  out 1        a port is selected
//   data_o   out DW       data of the selected port
//   ready_i  in  1        sink ready
module prim_arbiter_rr
  import prim_arbiter_pkg::*;
#(
  parameter  int N          = 8,
  parameter  int DW         = 32,
  parameter  int EnDataPort = 1,
  parameter  int RoundRobin = 1,
  localparam int IdxW       = arb_idx_w(N)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N-1:0]      req_i,
  input  logic [DW-1:0]     data_i [N],
  input  logic [N-1:0]      last_i,
  output logic [N-1:0]      gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o,
  output logic [DW-1:0]     data_o,
  input  logic              ready_i
);

  localparam arb_mode_e Mode = (RoundRobin != 0) ? ArbRoundRobin : ArbFixed;

  if (N == 1) begin : g_bypass

    // Single port: nothing to arbitrate and no state to keep.
    logic unused_bypass;
    assign unused_bypass = clk_i ^ (^last_i);

    assign valid_o = ~rst_i & req_i[0];
    assign idx_o   = '0;
    assign gnt_o   = valid_o & ready_i;
    assign data_o  = (EnDataPort != 0 && valid_o) ? data_i[0] : '0;

  end else begin : g_arb

    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] lock_idx_q;
    logic            lock_q;
    logic            pick_found;
    logic [IdxW-1:0] pick_idx;
    logic            lock_hold;
    logic            sel_valid;
    logic [IdxW-1:0] sel_idx;
    logic            handshake;
    logic            ptr_adv;
    logic [IdxW-1:0] ptr_next;

    prim_arbiter_rr_pick #(
      .N    (N),
      .IdxW (IdxW)
    ) u_pick (
      .req   (req_i),
      .ptr   (ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
    );

    // A lock only holds while its owner keeps requesting; if the owner
    // drops out the lock is ignored this cycle and normal picking resumes.
    assign lock_hold = lock_q & req_i[lock_idx_q];

`ifdef PRIM_ARBITER_PKT_LOCK_EN
    logic            pkt_q;
    logic [IdxW-1:0] pkt_idx_q;
`endif

    // Selection priority: packet lock over stall lock over the pick.
    always_comb begin
      sel_valid = pick_found;
      sel_idx   = pick_idx;
      if (lock_hold) begin
        sel_valid = 1'b1;
        sel_idx   = lock_idx_q;
      end
`ifdef PRIM_ARBITER_PKT_LOCK_EN
      if (pkt_q) begin
        sel_valid = req_i[pkt_idx_q];
        sel_idx   = pkt_idx_q;
      end
`endif
    end

    assign valid_o   = ~rst_i & sel_valid;
    assign idx_o     = valid_o ? sel_idx : '0;
    assign handshake = valid_o & ready_i;
    assign data_o    = (EnDataPort != 0 && valid_o) ? data_i[idx_o] : '0;

    // Grant is the handshake decoded onto the selected port.
    always_comb begin
      gnt_o = '0;
      if (handshake) gnt_o[idx_o] = 1'b1;
    end

    // Explicit wrap compare keeps non-power-of-2 N inside 0..N-1.
    assign ptr_next = (idx_o == IdxW'(N - 1)) ? '0 : idx_o + IdxW'(1);

`ifdef PRIM_ARBITER_PKT_LOCK_EN
    assign ptr_adv = handshake & last_i[idx_o];

    // Packet lock: a non-last beat pins the selection to its port until
    // the beat flagged last has been accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        pkt_q     <= 1'b0;
        pkt_idx_q <= '0;
      end else if (handshake) begin
        if (last_i[idx_o]) begin
          pkt_q <= 1'b0;
        end else begin
          pkt_q     <= 1'b1;
          pkt_idx_q <= idx_o;
        end
      end
    end
`else
    logic unused_last;
    assign unused_last = ^last_i;
    assign ptr_adv     = handshake;
`endif

    // Stall lock and rotating pointer. A stalled offer captures its index
    // so higher-priority arrivals cannot steal the slot; any cycle without
    // a stalled offer releases the lock. The pointer only moves in
    // round-robin mode, so fixed mode keeps searching from port 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        ptr_q      <= '0;
        lock_q     <= 1'b0;
        lock_idx_q <= '0;
      end else begin
        if (handshake) begin
          lock_q <= 1'b0;
        end else if (valid_o) begin
          lock_q     <= 1'b1;
          lock_idx_q <= idx_o;
        end else begin
          lock_q <= 1'b0;
        end
        if (Mode == ArbRoundRobin && ptr_adv) ptr_q <= ptr_next;
      end
    end

    // Interface invariants.
    a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
      $onehot0(gnt_o));
    a_gnt_hs: assert property (@(posedge clk_i) disable iff (rst_i)
      (|gnt_o) |-> (ready_i && valid_o));
`ifndef PRIM_ARBITER_PKT_LOCK_EN
    a_req_valid: assert property (@(posedge clk_i) disable iff (rst_i)
      (|req_i) |-> valid_o);
`endif
    a_valid_req: assert property (@(posedge clk_i) disable iff (rst_i)
      valid_o |-> req_i[idx_o]);
    a_data: assert property (@(posedge clk_i) disable iff (rst_i)
      (valid_o && EnDataPort != 0) |-> (data_o == data_i[idx_o]));
    a_idx_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (valid_o && !ready_i) |=> ((idx_o == $past(idx_o)) || !req_i[$past(idx_o)]));
    a_lock_owner_holds: assert property (@(posedge clk_i) disable iff (rst_i)
      lock_q |-> req_i[lock_idx_q]);

  end

endmodule

// File: doc/prim_arbiter_rr.md
Name: prim_arbiter_rr

Overview:
N:1 arbiter with per-instance selectable fixed-priority or round-robin mode. It is the parametrised successor of the fixed-priority tree arbiter. It adds a rotating priority pointer and a stable-grant lock that holds the selection while valid_o is stalled by ready_i. An optional multi-beat packet lock is also available. It sits in front of shared bus or FIFO sinks in the interconnect and peripheral-mux paths.

Parameters:
- N, 8: number of request ports; must be >= 1.
- DW, 32: data width.
- EnDataPort, 1: 0 means data_i is ignored and data_o is tied to '0.
- RoundRobin, 1: 0 is fixed priority (index 0 highest); 1 is rotating priority.
- IdxW, $clog2(N) with minimum 1: localparam, width of idx_o.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active high.
- req_i  in  N  per-port request (valid).
- data_i  in  DW x N  per-port data (unpacked array [N]).
- last_i  in  N  per-port last-beat flag; used only with the optional feature.
- gnt_o  out  N  one-hot0 grant; gnt_o[k] = valid_o & ready_i & (idx_o == k).
- idx_o  out  IdxW  index of the selected port.
- valid_o  out  1  OR of the arbitration result.
- data_o  out  DW  data of the selected port.
- ready_i  in  1  sink ready.

Behaviour:
- Reset state: ptr_q=0, lock_q=0, lock_idx_q=0.
- While rst_i is high, all outputs are forced: valid_o=0, gnt_o=0, idx_o=0, data_o=0.
- Datapath is combinational, zero cycles from req_i to valid_o/idx_o/data_o/gnt_o. State updates on the clk_i rising edge.
- Pick function: search req_i starting at ptr_q, ascending with wrap mod N; the first set bit wins.
  - Fixed mode: ptr_q is permanently 0.
- No request: valid_o=0, idx_o=0, data_o=0, gnt_o=0.
- Stable-grant lock:
  - If valid_o & ~ready_i, set lock_q=1 and lock_idx_q=idx_o.
  - While lock_q=1 and req_i[lock_idx_q]=1, the selection is lock_idx_q regardless of higher-priority requests.
  - lock_q clears on the handshake (valid_o & ready_i).
  - If the locked requestor drops req_i[lock_idx_q] (protocol violation), the lock is released the same cycle and normal picking applies. An assertion flags this in simulation.
- Pointer update (RoundRobin=1 only), on handshake: ptr_q <= (idx_o == N-1) ? 0 : idx_o+1. Non-power-of-2 N must wrap correctly, never reaching an out-of-range index.
- Simultaneous new request and handshake: the new request competes in the next cycle against the updated pointer.
- Reset asserted mid-lock: lock and pointer are cleared immediately (async). After release, arbitration restarts from port 0.
- N=1: bypass. valid_o=req_i[0], data_o=data_i[0], gnt_o[0]=req_i[0]&ready_i, idx_o=0, no state.
- Assertions (clk_i, disabled during rst_i):
  - gnt_o is onehot0.
  - |gnt_o implies ready_i & valid_o.
  - |req_i implies valid_o.
  - valid_o implies req_i[idx_o].
  - data_o == data_i[idx_o] when valid_o and EnDataPort.
  - idx_o is stable while valid_o & ~ready_i.

Optional Feature:
- Macro PRIM_ARBITER_PKT_LOCK_EN.
- Defined:
  - A handshake with last_i[idx_o]=0 sets pkt_q=1 and pkt_idx_q=idx_o.
  - While pkt_q=1, the selection is forced to pkt_idx_q. valid_o=req_i[pkt_idx_q]; other ports receive no grant even if they request.
  - pkt_q clears on the handshake where last_i[pkt_idx_q]=1.
  - The pointer advances only on that last-beat handshake.
  - Reset clears pkt_q.
- Not defined: last_i is unused (sunk to an unused_ signal); every beat is arbitrated independently.

Decomposition:
- Package prim_arbiter_pkg holds:
  - localparam function arb_idx_w(n), returning max(1, clog2(n)).
  - arb_mode_e enum: ArbFixed=0, ArbRoundRobin=1. The RoundRobin bit maps onto it.
- Sub-module prim_arbiter_rr_pick: purely combinational rotate-priority finder.
  - Inputs: req, ptr. Outputs: found, idx.
  - Implemented with a double-width masked leading-one search.
  - Instantiated once.

Test Plan:
1. Reset: rst_i=1 with req_i=4'b1111, ready_i=1 (N=4, RR) -> valid_o=0, gnt_o=0. Release, all requesting -> grants cycle 0,1,2,3,0 on successive cycles.
2. Fixed mode (RoundRobin=0): req_i=4'b1010, ready_i=1 for 3 cycles -> gnt_o=4'b0010 each cycle, idx_o=1.
3. Stall lock: req_i=4'b0100, ready_i=0, then req_i=4'b0101 while ready_i=0 for 2 cycles -> idx_o holds 2, gnt_o=0. ready_i=1 -> gnt_o=4'b0100. Next cycle -> gnt_o=4'b0001 (port 0 wins).
4. Non-power-of-2 wrap: N=5, req_i=5'b10001, ready_i=1 -> grants 0,4,0,4; idx_o never exceeds 4.
5. Mid-lock reset: stall on idx 3 (ptr_q=3), pulse rst_i for one cycle, then req_i=4'b1001, ready_i=1 -> grant port 0 first.
6. PRIM_ARBITER_PKT_LOCK_EN: port1 sends 3 beats with last_i[1] only on beat 3 while port0 requests continuously -> gnt_o=4'b0010 for 3 handshakes, then port0 granted next cycle.
